// File: rtl/fpadd_param_pipe.sv
// ---------------------------------------------------------------------------
// fpadd_param_pipe
//   Parametrised 3-stage pipelined floating-point adder/subtractor with
//   valid/ready flow control. Subnormal inputs are flushed to zero. Rounding
//   is round-to-nearest-even. Zero, infinity and NaN operands are handled.
//
//   Stage 1: unpack, classify, resolve special operands, order by magnitude
//   Stage 2: align the smaller significand and add/subtract
//   Stage 3: normalise, round, detect overflow/underflow, pack
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high; flushes every stage
//   in_valid   in   1      operands/op/tag valid
//   in_ready   out  1      transfer in when in_valid & in_ready
//   op_a       in   W      operand A {sign, exp, frac}
//   op_b       in   W      operand B
//   op_sub     in   1      0: A+B, 1: A-B
//   in_tag     in   TAG_W  opaque tag returned with the result
//   out_valid  out  1      result valid
//   out_ready  in   1      transfer out when out_valid & out_ready
//   result     out  W      packed sum
//   out_tag    out  TAG_W  tag of this result
//   out_flags  out  4      {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fpadd_param_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     op_a,
   input  logic [W-1:0]     op_b,
   input  logic             op_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     result,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_flags
);

   // significand layout: {hidden, frac, guard, round, sticky}
   localparam int SIG_W     = MAN_W + 4;
   localparam int SUM_W     = SIG_W + 1;
   localparam int LZ_W      = $clog2(SIG_W + 1);
   localparam int XE_W      = EXP_W + 2;
   localparam int SHIFT_MAX = MAN_W + 3;

   localparam logic [EXP_W-1:0]       EXP_ONES = {EXP_W{1'b1}};
   localparam logic signed [XE_W-1:0] EXP_INF  = $signed({2'b00, {EXP_W{1'b1}}});
   localparam logic [W-1:0]           QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // Leading-zero count of a significand; returns SIG_W for an all-zero input.
   function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
      logic [LZ_W-1:0] n;
      logic            found;
      n     = LZ_W'(SIG_W);
      found = 1'b0;
      for (int i = SIG_W - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = LZ_W'(SIG_W - 1 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   logic adv;

   // stage 1 registers
   logic             s1_valid_q, s1_valid_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic             s1_sign_q, s1_sign_d;
   logic             s1_sub_q, s1_sub_d;
   logic [EXP_W-1:0] s1_ex_q, s1_ex_d, s1_ey_q, s1_ey_d;
   logic [MAN_W-1:0] s1_fx_q, s1_fx_d, s1_fy_q, s1_fy_d;
   logic             s1_spec_q, s1_spec_d;
   logic [W-1:0]     s1_spec_res_q, s1_spec_res_d;
   logic [3:0]       s1_spec_flags_q, s1_spec_flags_d;

   // stage 2 registers
   logic             s2_valid_q, s2_valid_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
   logic             s2_sign_q, s2_sign_d;
   logic [EXP_W-1:0] s2_ex_q, s2_ex_d;
   logic [SUM_W-1:0] s2_sum_q, s2_sum_d;
   logic             s2_spec_q, s2_spec_d;
   logic [W-1:0]     s2_spec_res_q, s2_spec_res_d;
   logic [3:0]       s2_spec_flags_q, s2_spec_flags_d;

   // output registers
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     result_q, result_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic [3:0]       out_flags_q, out_flags_d;

   // stage 1 decode
   logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;

   // stage 2 datapath
   logic [EXP_W-1:0] s2_d_exp;
   logic [SIG_W-1:0] mx, my, aligned, mask;
   logic [SUM_W-1:0] sum_n;

   // stage 3 datapath
   logic [LZ_W-1:0]         lz;
   logic [SIG_W-1:0]        norm_m;
   logic signed [XE_W-1:0]  ex_ext, norm_e, fin_e;
   logic [MAN_W+1:0]        rnd;
   logic [MAN_W-1:0]        fin_f;
   logic                    g_bit, r_bit, s_bit, round_up, inexact;
   logic [W-1:0]            res_n;
   logic [3:0]              flags_n;

   // Every stage advances together whenever the output slot is free or draining.
   always_comb begin
      adv      = !out_valid_q || out_ready;
      in_ready = adv;
   end

   // Stage 1: classify operands, resolve special cases, order by magnitude.
   always_comb begin
      a_sign = op_a[W-1];
      b_sign = op_b[W-1] ^ op_sub;
      a_exp  = op_a[W-2:MAN_W];
      b_exp  = op_b[W-2:MAN_W];
      a_frac = op_a[MAN_W-1:0];
      b_frac = op_b[MAN_W-1:0];
      a_zero = (a_exp == {EXP_W{1'b0}});
      b_zero = (b_exp == {EXP_W{1'b0}});
      a_inf  = (a_exp == EXP_ONES) && (a_frac == {MAN_W{1'b0}});
      b_inf  = (b_exp == EXP_ONES) && (b_frac == {MAN_W{1'b0}});
      a_nan  = (a_exp == EXP_ONES) && (a_frac != {MAN_W{1'b0}});
      b_nan  = (b_exp == EXP_ONES) && (b_frac != {MAN_W{1'b0}});
      swap   = (op_b[W-2:0] > op_a[W-2:0]);

      s1_valid_d      = s1_valid_q;
      s1_tag_d        = s1_tag_q;
      s1_sign_d       = s1_sign_q;
      s1_sub_d        = s1_sub_q;
      s1_ex_d         = s1_ex_q;
      s1_ey_d         = s1_ey_q;
      s1_fx_d         = s1_fx_q;
      s1_fy_d         = s1_fy_q;
      s1_spec_d       = s1_spec_q;
      s1_spec_res_d   = s1_spec_res_q;
      s1_spec_flags_d = s1_spec_flags_q;

      if (adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_tag_d = in_tag;
            s1_sub_d = a_sign ^ b_sign;
            if (swap) begin
               s1_sign_d = b_sign;
               s1_ex_d   = b_exp;
               s1_ey_d   = a_exp;
               s1_fx_d   = b_frac;
               s1_fy_d   = a_frac;
            end else begin
               s1_sign_d = a_sign;
               s1_ex_d   = a_exp;
               s1_ey_d   = b_exp;
               s1_fx_d   = a_frac;
               s1_fy_d   = b_frac;
            end

            s1_spec_d       = 1'b1;
            s1_spec_flags_d = 4'b0000;
            if (a_nan || b_nan) begin
               s1_spec_res_d = QNAN;
            end else if (a_inf && b_inf && (a_sign != b_sign)) begin
               s1_spec_res_d   = QNAN;
               s1_spec_flags_d = 4'b1000;
            end else if (a_inf) begin
               s1_spec_res_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
            end else if (b_inf) begin
               s1_spec_res_d = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
            end else if (a_zero && b_zero) begin
               // only (-0)+(-0) keeps the negative sign
               s1_spec_res_d = {a_sign & b_sign, {(W-1){1'b0}}};
            end else if (a_zero) begin
               s1_spec_res_d = {b_sign, op_b[W-2:0]};
            end else if (b_zero) begin
               s1_spec_res_d = {a_sign, op_a[W-2:0]};
            end else begin
               s1_spec_d     = 1'b0;
               s1_spec_res_d = {W{1'b0}};
            end
         end else begin
            s1_spec_d = 1'b0;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Stage 2: align the smaller significand with sticky collection, then add/subtract.
   always_comb begin
      s2_d_exp = s1_ex_q - s1_ey_q;
      mx       = {1'b1, s1_fx_q, 3'b000};
      my       = {1'b1, s1_fy_q, 3'b000};
      mask     = {SIG_W{1'b0}};
      if (int'(s2_d_exp) >= SHIFT_MAX) begin
         // Y lies entirely below the sticky position
         aligned = {{(SIG_W-1){1'b0}}, 1'b1};
      end else begin
         mask    = ~({SIG_W{1'b1}} << s2_d_exp);
         aligned = (my >> s2_d_exp) | {{(SIG_W-1){1'b0}}, |(my & mask)};
      end
      if (s1_sub_q) begin
         sum_n = {1'b0, mx} - {1'b0, aligned};
      end else begin
         sum_n = {1'b0, mx} + {1'b0, aligned};
      end

      s2_valid_d      = s2_valid_q;
      s2_tag_d        = s2_tag_q;
      s2_sign_d       = s2_sign_q;
      s2_ex_d         = s2_ex_q;
      s2_sum_d        = s2_sum_q;
      s2_spec_d       = s2_spec_q;
      s2_spec_res_d   = s2_spec_res_q;
      s2_spec_flags_d = s2_spec_flags_q;
      if (adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_tag_d        = s1_tag_q;
            s2_sign_d       = s1_sign_q;
            s2_ex_d         = s1_ex_q;
            s2_sum_d        = sum_n;
            s2_spec_d       = s1_spec_q;
            s2_spec_res_d   = s1_spec_res_q;
            s2_spec_flags_d = s1_spec_flags_q;
         end else begin
            s2_spec_d = 1'b0;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Stage 3: normalise, round to nearest-even, range-check and pack.
   always_comb begin
      ex_ext = $signed({2'b00, s2_ex_q});
      lz     = lzc(s2_sum_q[SIG_W-1:0]);
      if (s2_sum_q[SUM_W-1]) begin
         // carry out: drop one bit into sticky
         norm_m = s2_sum_q[SUM_W-1:1] | {{(SIG_W-1){1'b0}}, s2_sum_q[0]};
         norm_e = ex_ext + $signed({{(XE_W-1){1'b0}}, 1'b1});
      end else begin
         norm_m = s2_sum_q[SIG_W-1:0] << lz;
         norm_e = ex_ext - $signed({{(XE_W-LZ_W){1'b0}}, lz});
      end

      g_bit    = norm_m[2];
      r_bit    = norm_m[1];
      s_bit    = norm_m[0];
      round_up = g_bit & (r_bit | s_bit | norm_m[3]);
      inexact  = g_bit | r_bit | s_bit;
      rnd      = {1'b0, norm_m[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
      if (rnd[MAN_W+1]) begin
         fin_e = norm_e + $signed({{(XE_W-1){1'b0}}, 1'b1});
         fin_f = rnd[MAN_W:1];
      end else begin
         fin_e = norm_e;
         fin_f = rnd[MAN_W-1:0];
      end

      if (s2_spec_q) begin
         res_n   = s2_spec_res_q;
         flags_n = s2_spec_flags_q;
      end else if (s2_sum_q == {SUM_W{1'b0}}) begin
         // exact cancellation of nonzero operands gives +0
         res_n   = {W{1'b0}};
         flags_n = 4'b0000;
      end else if (fin_e >= EXP_INF) begin
         res_n   = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
         flags_n = 4'b0101;
      end else if (fin_e[XE_W-1] || (fin_e == {XE_W{1'b0}})) begin
         res_n   = {s2_sign_q, {(W-1){1'b0}}};
         flags_n = 4'b0011;
      end else begin
         res_n   = {s2_sign_q, fin_e[EXP_W-1:0], fin_f};
         flags_n = {3'b000, inexact};
      end

      out_valid_d = out_valid_q;
      result_d    = result_q;
      out_tag_d   = out_tag_q;
      out_flags_d = out_flags_q;
      if (adv) begin
         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            result_d    = res_n;
            out_tag_d   = s2_tag_q;
            out_flags_d = flags_n;
         end else begin
            out_flags_d = out_flags_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Pipeline state; reset drops every in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q      <= 1'b0;
         s1_tag_q        <= {TAG_W{1'b0}};
         s1_sign_q       <= 1'b0;
         s1_sub_q        <= 1'b0;
         s1_ex_q         <= {EXP_W{1'b0}};
         s1_ey_q         <= {EXP_W{1'b0}};
         s1_fx_q         <= {MAN_W{1'b0}};
         s1_fy_q         <= {MAN_W{1'b0}};
         s1_spec_q       <= 1'b0;
         s1_spec_res_q   <= {W{1'b0}};
         s1_spec_flags_q <= 4'b0000;
         s2_valid_q      <= 1'b0;
         s2_tag_q        <= {TAG_W{1'b0}};
         s2_sign_q       <= 1'b0;
         s2_ex_q         <= {EXP_W{1'b0}};
         s2_sum_q        <= {SUM_W{1'b0}};
         s2_spec_q       <= 1'b0;
         s2_spec_res_q   <= {W{1'b0}};
         s2_spec_flags_q <= 4'b0000;
         out_valid_q     <= 1'b0;
         result_q        <= {W{1'b0}};
         out_tag_q       <= {TAG_W{1'b0}};
         out_flags_q     <= 4'b0000;
      end else begin
         s1_valid_q      <= s1_valid_d;
         s1_tag_q        <= s1_tag_d;
         s1_sign_q       <= s1_sign_d;
         s1_sub_q        <= s1_sub_d;
         s1_ex_q         <= s1_ex_d;
         s1_ey_q         <= s1_ey_d;
         s1_fx_q         <= s1_fx_d;
         s1_fy_q         <= s1_fy_d;
         s1_spec_q       <= s1_spec_d;
         s1_spec_res_q   <= s1_spec_res_d;
         s1_spec_flags_q <= s1_spec_flags_d;
         s2_valid_q      <= s2_valid_d;
         s2_tag_q        <= s2_tag_d;
         s2_sign_q       <= s2_sign_d;
         s2_ex_q         <= s2_ex_d;
         s2_sum_q        <= s2_sum_d;
         s2_spec_q       <= s2_spec_d;
         s2_spec_res_q   <= s2_spec_res_d;
         s2_spec_flags_q <= s2_spec_flags_d;
         out_valid_q     <= out_valid_d;
         result_q        <= result_d;
         out_tag_q       <= out_tag_d;
         out_flags_q     <= out_flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign out_tag   = out_tag_q;
   assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fpadd_param_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpadd_param_pipe
//   Table of hand-computed FP32 vectors pushed through a scoreboard, plus
//   sequences for latency, a stalled back-to-back stream and mid-flight reset.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fpadd_param_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_sub;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  out_tag;
   logic [3:0]  out_flags;

   fpadd_param_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag),
      .out_flags (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic [3:0]  flags;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flags;
      logic [3:0]  tag;
   } exp_t;

   localparam int NV = 27;
   vec_t vecs [NV];
   exp_t sb_q [$];

   int n_vec = 0;
   int n_err = 0;
   int rdy_low = 0;

   logic        held_v = 1'b0;
   logic [31:0] held_res;
   logic [3:0]  held_tag;
   logic [3:0]  held_flags;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [3:0] tag, input logic ordy,
                        input logic [31:0] eres, input logic [3:0] eflags, output logic acc);
      exp_t e;
      if (held_v) begin
         n_vec++;
         if (!out_valid || result !== held_res || out_tag !== held_tag || out_flags !== held_flags) begin
            n_err++;
            $display("FAIL hold_stable: got v=%b %h tag %h flags %b, required v=1 %h tag %h flags %b",
                     out_valid, result, out_tag, out_flags, held_res, held_tag, held_flags);
         end
      end
      in_valid  = iv;
      op_a      = a;
      op_b      = b;
      op_sub    = sub;
      in_tag    = tag;
      out_ready = ordy;
      #1;
      if (!in_ready) rdy_low++;
      held_v     = out_valid && !out_ready;
      held_res   = result;
      held_tag   = out_tag;
      held_flags = out_flags;
      if (out_valid && out_ready) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got %h tag %h, required no output", result, out_tag);
         end else begin
            e = sb_q.pop_front();
            if (result !== e.res || out_flags !== e.flags || out_tag !== e.tag) begin
               n_err++;
               $display("FAIL result_tag%0d: got %h flags %b tag %h, required %h flags %b tag %h",
                        e.tag, result, out_flags, out_tag, e.res, e.flags, e.tag);
            end
         end
      end
      acc = in_valid && in_ready;
      if (acc) sb_q.push_back('{res: eres, flags: eflags, tag: tag});
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, ordy, 32'h0, 4'h0, acc);
   endtask

   task automatic send(input int idx, input logic [3:0] tag);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++)
         cycle(1'b1, vecs[idx].a, vecs[idx].b, vecs[idx].sub, tag, 1'b1,
               vecs[idx].res, vecs[idx].flags, acc);
      if (!acc) begin
         n_err++;
         $display("FAIL accept_timeout: got no accept for vector %0d, required accept", idx);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb_q.size() > 0; t++) idle(1'b1);
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic latency_check(input string name, input logic [3:0] tag);
      int lat;
      lat = 0;
      send(0, tag);
      for (int k = 1; k <= 8; k++) begin
         if (out_valid && lat == 0) lat = k;
         idle(1'b1);
      end
      chk(name, 32'(lat), 32'd3);
   endtask

   initial begin
      vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
      vecs[1]  = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000};
      vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
      vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
      vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
      vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
      vecs[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
      vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
      vecs[8]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000};
      vecs[9]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
      vecs[10] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
      vecs[11] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000};
      vecs[12] = '{32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 4'b0000};
      vecs[13] = '{32'h40000000, 32'h00000000, 1'b1, 32'h40000000, 4'b0000};
      vecs[14] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000};
      vecs[15] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011};
      vecs[16] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
      vecs[17] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000};
      vecs[18] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001};
      vecs[19] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
      vecs[20] = '{32'h5F800000, 32'h3F800000, 1'b0, 32'h5F800000, 4'b0001};
      vecs[21] = '{32'h3F800000, 32'hFF800001, 1'b0, 32'h7FC00000, 4'b0000};
      vecs[22] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
      vecs[23] = '{32'hFF800000, 32'h00000000, 1'b0, 32'hFF800000, 4'b0000};
      vecs[24] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101};
      vecs[25] = '{32'h40A00000, 32'hC0400000, 1'b0, 32'h40000000, 4'b0000};
      vecs[26] = '{32'h3F800000, 32'hC0400000, 1'b0, 32'hC0000000, 4'b0000};

      reset     = 1'b1;
      in_valid  = 1'b0;
      op_a      = 32'h0;
      op_b      = 32'h0;
      op_sub    = 1'b0;
      in_tag    = 4'h0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", result, 32'h0);
      chk("reset_tag", 32'(out_tag), 32'd0);
      chk("reset_flags", 32'(out_flags), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // latency of a lone operation into an empty pipe
      latency_check("latency", 4'hA);

      // table of vectors, back-to-back
      for (int i = 0; i < NV; i++) send(i, 4'(i));
      drain();

      // stream tags 0..7 with a 5-cycle output stall in the middle
      begin
         int  sent;
         logic acc;
         int  idx;
         sent    = 0;
         rdy_low = 0;
         for (int c = 0; c < 60 && (sent < 8 || sb_q.size() > 0); c++) begin
            idx = (sent < 8) ? sent : 0;
            cycle(sent < 8, vecs[idx].a, vecs[idx].b, vecs[idx].sub, 4'(sent),
                  !(c >= 4 && c < 9), vecs[idx].res, vecs[idx].flags, acc);
            if (acc) sent++;
         end
         chk("stream_sent", 32'(sent), 32'd8);
         chk("stream_drained", 32'(sb_q.size()), 32'd0);
         chk("stream_in_ready_dropped", 32'(rdy_low > 0), 32'd1);
      end

      // reset with three operations in flight
      send(0, 4'h1);
      send(5, 4'h2);
      send(6, 4'h3);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      held_v    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_result", result, 32'h0);
      chk("midreset_tag", 32'(out_tag), 32'd0);
      chk("midreset_flags", 32'(out_flags), 32'd0);
      chk("midreset_in_ready", 32'(in_ready), 32'd1);
      sb_q.delete();
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         chk("no_stale", 32'(out_valid), 32'd0);
         idle(1'b1);
      end
      latency_check("post_reset_latency", 4'h7);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, required completion");
      $fatal(1);
   end

endmodule
